dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: the core load/store path (port c_) and a DMA/debug engine (port d_).
- Drives the memory's write-enable, read-enable, address, RW_type and write-data inputs, and takes its combinational read data.
- Round-robin arbitration, plus a bounded DMA lock for bursts.
- Rejects misaligned and out-of-range accesses with an error response, without touching memory.

---
 rtl/dmem_arbiter_pkg.sv | 36 +++
 rtl/dmem_req_check.sv | 18 +
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter:
// RW_type sizes, arbiter states and the muxed request bundle.
package dmem_arbiter_pkg;

  localparam logic [1:0] RW_BYTE = 2'b00;
  localparam logic [1:0] RW_HALF = 2'b01;
  localparam logic [1:0] RW_WORD = 2'b10;
  localparam int RW_UNS_BIT = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    PTR_CORE = 1'b0,
    PTR_DMA  = 1'b1
  } arb_ptr_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  rw_type;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == 2'b11)
      | ((size == RW_HALF) & lo[0])
      | ((size == RW_WORD) & (|lo));
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational alignment and range check
// for the request currently steered to memory.
module dmem_req_check
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        err
);

  logic oor;

  assign oor = |(addr >> MEM_AW);
  assign err = oor | misaligned(size, addr[1:0]);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between core and DMA for the single-port
// data memory, with a bounded DMA burst lock and error responses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 8,
  parameter int MEM_AW   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [2:0]  c_type,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_type,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        d_lock,
  output logic        mem_W_en,
  output logic        mem_R_en,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_RW_type,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  // Last lock cycle: the grant that brings the count to LOCK_MAX.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  arb_state_t state;
  arb_ptr_t   ptr;
  logic [7:0] lock_cnt;
  logic       c_win;
  logic       d_win;
  logic       err;
  logic       hit;
  mem_req_t   req;

  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          c_win = c_req & (!d_req | (ptr == PTR_CORE));
          d_win = d_req & (!c_req | (ptr == PTR_DMA));
        end
        LOCKED: d_win = d_req;
        default: ;
      endcase
    end
  end

  assign c_gnt = c_win;
  assign d_gnt = d_win;

  always_comb begin
    req = '0;
    if (d_win) begin
      req = '{we: d_we, addr: d_addr,
              rw_type: d_type, wdata: d_wdata};
    end else if (c_win) begin
      req = '{we: c_we, addr: c_addr,
              rw_type: c_type, wdata: c_wdata};
    end
  end

  dmem_req_check #(
    .MEM_AW(MEM_AW)
  ) u_check (
    .addr(req.addr),
    .size(req.rw_type[1:0]),
    .err (err)
  );

  // Rejected requests never reach the memory pins.
  assign hit         = (c_win | d_win) & !err;
  assign mem_W_en    = hit & req.we;
  assign mem_R_en    = hit & !req.we;
  assign mem_addr    = hit ? req.addr : '0;
  assign mem_RW_type = hit ? req.rw_type : '0;
  assign mem_din     = hit ? req.wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_win;
      c_err    <= c_win & err;
      c_rdata  <= (c_win & mem_R_en) ? mem_dout : '0;
      d_rvalid <= d_win;
      d_err    <= d_win & err;
      d_rdata  <= (d_win & mem_R_en) ? mem_dout : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      ptr      <= PTR_CORE;
      lock_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (c_win) ptr <= PTR_DMA;
          if (d_win) ptr <= PTR_CORE;
          if (d_win && d_lock) begin
            state    <= LOCKED;
            lock_cnt <= 8'd1;
          end
        end
        LOCKED: begin
          // Idle cycles count too, so the core wait stays bounded.
          if (!d_lock || lock_cnt >= LOCK_LAST) begin
            state    <= ARB;
            ptr      <= PTR_CORE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 8'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
